spi_move_slave: RTL and testbench
=================================

Name: spi_move_slave

Overview:
SPI responder (mode 0, MSB-first, 8-bit frames) for the tic-tac-toe board. It is the far end of the game's SPI move-index link and lets the FPGA act as the peripheral: an external master sends a move byte and simultaneously reads back a status byte. Received bytes are decoded into a 5-bit move index with a validity strobe for matrixControl, and tx_data is provided by the game FSM. All SPI pins are asynchronous to clk and are synchronised internally.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the sclk/cs_n/mosi synchronisers (minimum 2).
HEADER, 3'b101, value required in rx byte bits [7:5] for the byte to count as a move command.
MAX_INDEX, 8, highest legal board cell index (cells 0..8).

Ports:
clk  in  1  system clock; sclk must be at most clk/8.
rst  in  1  asynchronous reset, active-high.
sclk  in  1  SPI clock from master; idles low.
cs_n  in  1  SPI chip select, active-low.
mosi  in  1  master-out data.
miso  out  1  slave-out data; 0 when not selected.
miso_oe  out  1  high while a frame is active, for an optional tri-state pad.
tx_data  in  8  status byte; sampled at frame start and at each byte boundary.
rx_data  out  8  last complete received byte.
rx_valid  out  1  one-cycle pulse when a full byte has been received.
move_index  out  5  rx_data[4:0] from the last valid move command.
move_valid  out  1  one-cycle pulse when a decoded move is legal.
move_err  out  1  one-cycle pulse when the header matched but the index is greater than MAX_INDEX.
busy  out  1  high from the synchronised cs_n fall to the synchronised cs_n rise.

Behaviour:
- Reset (async, immediate): every output is 0, the bit counter is 0, the shift registers are 0, and the FSM is in IDLE. Synchronisers reset cs_n to 1 and sclk and mosi to 0.
- Synchronisation: each input passes through SYNC_STAGES flops plus one history flop for edge detection. All edge events are single-clk pulses in the clk domain.
- FSM states:
  - IDLE: miso=0, miso_oe=0, busy=0. On the synchronised cs_n fall: latch tx_data into tx_shift, drive miso=tx_data[7], set bit_cnt=0, go to ACTIVE.
  - ACTIVE:
    - sclk rise: rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt++.
    - sclk fall: if bit_cnt != 0, tx_shift <= tx_shift<<1 and miso=new MSB.
    - If bit_cnt reaches 8 on a rise: rx_data <= completed byte and rx_valid pulses on the next cycle; bit_cnt wraps to 0.
    - The next sclk fall (bit_cnt==0) reloads tx_shift from the current tx_data (burst mode: multiple bytes per cs_n assertion).
  - Synchronised cs_n rise in ACTIVE: go to IDLE; the partial byte is discarded with no rx_valid; miso=0 on the same cycle.
- Decode: registered one cycle after rx_valid, i.e. move_valid and move_err fire 1 clk after rx_valid.
  - rx[7:5]==HEADER and rx[4:0]<=MAX_INDEX: move_index<=rx[4:0], move_valid=1.
  - rx[7:5]==HEADER and rx[4:0]>MAX_INDEX: move_err=1; move_index is unchanged.
  - Header mismatch: only rx_valid fires; there is no decode pulse.
- Latency: rx_valid is asserted no later than SYNC_STAGES+2 clk cycles after the 8th sclk rising edge at the pin.
- Simultaneous events:
  - sclk edge coinciding with the cs_n rise: cs_n takes priority and the edge is ignored.
  - sclk edges while in IDLE are ignored.
- tx_data changing mid-byte has no effect until the next reload point.
- rst asserted mid-frame: immediate return to IDLE with all outputs 0; no rx_valid for the aborted byte.
- Wrap: rx_data holds its value until the next full byte; move_index holds until the next legal move.

Test Plan:
1. Reset, then cs_n low, send 8'hA4 with tx_data=8'h3C -> master reads 8'h3C; rx_data=8'hA4; rx_valid pulses once; move_valid pulses 1 clk later with move_index=5'd4.
2. Send 8'hBF -> rx_valid pulses; move_err pulses; move_valid stays 0; move_index keeps its previous value 4.
3. Send 8'h04 (header mismatch) -> rx_valid pulses and rx_data=8'h04; no move_valid or move_err.
4. Burst of 8'hA1 then 8'hA8 under a single cs_n, with tx_data changed from 8'h11 to 8'h22 during byte 1 -> master reads 8'h11 then 8'h22; two rx_valid pulses; move_index ends at 8.
5. Deassert cs_n after 5 bits -> no rx_valid, busy drops, miso=0; the following full frame of 8'hA2 decodes correctly to index 2.
6. Assert rst after 3 bits of a frame -> all outputs 0 immediately; after release, with no cs_n edge, sclk toggles are ignored (rx_valid stays 0).

Source files
------------

// File: rtl/spi_move_slave_if.sv
// rtl/spi_move_slave_if.sv - SPI pins plus byte/move handshake between game logic and the move responder
interface spi_move_slave_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] move_index;
  logic       move_valid;
  logic       move_err;
  logic       busy;

  modport slave (
    input  sclk, cs_n, mosi, tx_data,
    output miso, miso_oe, rx_data, rx_valid, move_index, move_valid, move_err, busy
  );

  modport master (
    output sclk, cs_n, mosi, tx_data,
    input  miso, miso_oe, rx_data, rx_valid, move_index, move_valid, move_err, busy
  );
endinterface

// File: rtl/spi_move_slave.sv
// rtl/spi_move_slave.sv - SPI mode-0 responder decoding received bytes into board move indices
module spi_move_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] HEADER      = 3'b101,
  parameter int         MAX_INDEX   = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  spi_move_slave_if.slave bus
);

  localparam logic [4:0] MAX_IDX = 5'(MAX_INDEX);

  typedef enum logic [0:0] {IDLE, ACTIVE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_hist_q, cs_hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_shift_q, tx_shift_q, rx_data_q;
  logic       rx_valid_q, miso_q, miso_oe_q, busy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q    <= ACTIVE;
            tx_shift_q <= bus.tx_data;
            miso_q     <= bus.tx_data[7];
            bit_cnt_q  <= '0;
            miso_oe_q  <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACTIVE: begin
          // cs_n release wins over any sclk edge seen in the same cycle
          if (cs_rise) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift_q <= {rx_shift_q[6:0], mosi_s};
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_q  <= {rx_shift_q[6:0], mosi_s};
              rx_valid_q <= 1'b1;
            end
          end else if (sclk_fall) begin
            // a fall at bit 0 is the byte boundary: reload for the next burst byte
            if (bit_cnt_q != 3'd0) begin
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
              miso_q     <= tx_shift_q[6];
            end else begin
              tx_shift_q <= bus.tx_data;
              miso_q     <= bus.tx_data[7];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [4:0] move_index_q;
  logic       move_valid_q, move_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      move_index_q <= '0;
      move_valid_q <= 1'b0;
      move_err_q   <= 1'b0;
    end else begin
      move_valid_q <= 1'b0;
      move_err_q   <= 1'b0;
      if (rx_valid_q && rx_data_q[7:5] == HEADER) begin
        if (rx_data_q[4:0] <= MAX_IDX) begin
          move_index_q <= rx_data_q[4:0];
          move_valid_q <= 1'b1;
        end else begin
          move_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.miso       = miso_q;
  assign bus.miso_oe    = miso_oe_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.move_index = move_index_q;
  assign bus.move_valid = move_valid_q;
  assign bus.move_err   = move_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_spi_move_slave.sv
// tb/tb_spi_move_slave.sv - directed bench acting as SPI master for spi_move_slave
module tb_spi_move_slave;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  int   rxv_cnt = 0, mv_cnt = 0, me_cnt = 0, order_err = 0;
  logic rxv_prev = 1'b0;

  spi_move_slave_if bus();

  spi_move_slave #(.SYNC_STAGES(SYNC_STAGES), .HEADER(3'b101), .MAX_INDEX(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // decode pulses must land exactly one cycle after an rx_valid pulse
  always @(negedge clk) begin
    if (bus.rx_valid) rxv_cnt++;
    if (bus.move_valid) mv_cnt++;
    if (bus.move_err) me_cnt++;
    if ((bus.move_valid || bus.move_err) && !rxv_prev) order_err++;
    rxv_prev = bus.rx_valid;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] r, output int lat);
    r = '0;
    lat = 0;
    for (int i = 0; i < n; i++) begin
      bus.mosi = b[7-i];
      idle(4);
      bus.sclk = 1'b1;
      r[7-i] = bus.miso;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (i == 7 && lat == 0 && bus.rx_valid) lat = k;
      end
      bus.sclk = 1'b0;
      idle(4);
    end
  endtask

  task automatic frame(input logic [7:0] b, output logic [7:0] r, output int lat);
    bus.cs_n = 1'b0;
    idle(8);
    send_bits(b, 8, r, lat);
    bus.cs_n = 1'b1;
    idle(8);
  endtask

  task automatic test_reset;
    idle(4);
    checks++;
    if (bus.busy !== 1'b0 || bus.miso_oe !== 1'b0 || bus.miso !== 1'b0) begin
      errors++; $display("FAIL reset_ctl got busy=%b oe=%b miso=%b exp 0", bus.busy, bus.miso_oe, bus.miso);
    end
    checks++;
    if (bus.rx_data !== 8'h00 || bus.rx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rx got %h/%b exp 00/0", bus.rx_data, bus.rx_valid);
    end
    checks++;
    if (bus.move_index !== 5'd0 || bus.move_valid !== 1'b0 || bus.move_err !== 1'b0) begin
      errors++; $display("FAIL reset_move got %0d/%b/%b exp 0/0/0", bus.move_index, bus.move_valid, bus.move_err);
    end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_basic;
    logic [7:0] r;
    int lat, b_rx, b_mv, b_me;
    b_rx = rxv_cnt; b_mv = mv_cnt; b_me = me_cnt;
    bus.tx_data = 8'h3C;
    bus.cs_n = 1'b0;
    idle(8);
    checks++;
    if (bus.busy !== 1'b1 || bus.miso_oe !== 1'b1) begin
      errors++; $display("FAIL basic_busy got busy=%b oe=%b exp 1/1", bus.busy, bus.miso_oe);
    end
    send_bits(8'hA4, 8, r, lat);
    bus.cs_n = 1'b1;
    idle(8);
    checks++;
    if (r !== 8'h3C) begin errors++; $display("FAIL basic_miso got %h exp 3c", r); end
    checks++;
    if (bus.rx_data !== 8'hA4) begin errors++; $display("FAIL basic_rx_data got %h exp a4", bus.rx_data); end
    checks++;
    if (rxv_cnt - b_rx !== 1) begin errors++; $display("FAIL basic_rx_valid got %0d exp 1", rxv_cnt - b_rx); end
    checks++;
    if (lat < 1 || lat > SYNC_STAGES + 2) begin
      errors++; $display("FAIL basic_latency got %0d exp 1..%0d", lat, SYNC_STAGES + 2);
    end
    checks++;
    if (mv_cnt - b_mv !== 1 || me_cnt - b_me !== 0) begin
      errors++; $display("FAIL basic_decode got mv=%0d me=%0d exp 1/0", mv_cnt - b_mv, me_cnt - b_me);
    end
    checks++;
    if (bus.move_index !== 5'd4) begin errors++; $display("FAIL basic_index got %0d exp 4", bus.move_index); end
    checks++;
    if (bus.busy !== 1'b0 || bus.miso !== 1'b0) begin
      errors++; $display("FAIL basic_idle got busy=%b miso=%b exp 0/0", bus.busy, bus.miso);
    end
  endtask

  task automatic test_move_err;
    logic [7:0] r;
    int lat, b_rx, b_mv, b_me;
    b_rx = rxv_cnt; b_mv = mv_cnt; b_me = me_cnt;
    frame(8'hBF, r, lat);
    checks++;
    if (rxv_cnt - b_rx !== 1 || bus.rx_data !== 8'hBF) begin
      errors++; $display("FAIL err_rx got %0d/%h exp 1/bf", rxv_cnt - b_rx, bus.rx_data);
    end
    checks++;
    if (me_cnt - b_me !== 1 || mv_cnt - b_mv !== 0) begin
      errors++; $display("FAIL err_decode got me=%0d mv=%0d exp 1/0", me_cnt - b_me, mv_cnt - b_mv);
    end
    checks++;
    if (bus.move_index !== 5'd4) begin errors++; $display("FAIL err_index_hold got %0d exp 4", bus.move_index); end
  endtask

  task automatic test_mismatch;
    logic [7:0] r;
    int lat, b_rx, b_mv, b_me;
    b_rx = rxv_cnt; b_mv = mv_cnt; b_me = me_cnt;
    frame(8'h04, r, lat);
    checks++;
    if (rxv_cnt - b_rx !== 1 || bus.rx_data !== 8'h04) begin
      errors++; $display("FAIL mismatch_rx got %0d/%h exp 1/04", rxv_cnt - b_rx, bus.rx_data);
    end
    checks++;
    if (mv_cnt - b_mv !== 0 || me_cnt - b_me !== 0) begin
      errors++; $display("FAIL mismatch_decode got mv=%0d me=%0d exp 0/0", mv_cnt - b_mv, me_cnt - b_me);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] r1, r2;
    int lat1, lat2, b_rx, b_mv;
    b_rx = rxv_cnt; b_mv = mv_cnt;
    bus.tx_data = 8'h11;
    bus.cs_n = 1'b0;
    idle(8);
    fork
      send_bits(8'hA1, 8, r1, lat1);
      begin idle(30); bus.tx_data = 8'h22; end
    join
    send_bits(8'hA8, 8, r2, lat2);
    bus.cs_n = 1'b1;
    idle(8);
    checks++;
    if (r1 !== 8'h11 || r2 !== 8'h22) begin
      errors++; $display("FAIL burst_miso got %h %h exp 11 22", r1, r2);
    end
    checks++;
    if (rxv_cnt - b_rx !== 2 || mv_cnt - b_mv !== 2) begin
      errors++; $display("FAIL burst_pulses got rx=%0d mv=%0d exp 2/2", rxv_cnt - b_rx, mv_cnt - b_mv);
    end
    checks++;
    if (bus.move_index !== 5'd8 || bus.rx_data !== 8'hA8) begin
      errors++; $display("FAIL burst_final got %0d/%h exp 8/a8", bus.move_index, bus.rx_data);
    end
  endtask

  task automatic test_abort;
    logic [7:0] r;
    int lat, b_rx, b_mv;
    b_rx = rxv_cnt;
    bus.tx_data = 8'hFF;
    bus.cs_n = 1'b0;
    idle(8);
    send_bits(8'hA7, 5, r, lat);
    bus.cs_n = 1'b1;
    idle(6);
    checks++;
    if (bus.busy !== 1'b0 || bus.miso !== 1'b0 || bus.miso_oe !== 1'b0) begin
      errors++; $display("FAIL abort_idle got busy=%b miso=%b oe=%b exp 0", bus.busy, bus.miso, bus.miso_oe);
    end
    checks++;
    if (rxv_cnt - b_rx !== 0) begin errors++; $display("FAIL abort_no_rx got %0d exp 0", rxv_cnt - b_rx); end
    b_rx = rxv_cnt; b_mv = mv_cnt;
    frame(8'hA2, r, lat);
    checks++;
    if (rxv_cnt - b_rx !== 1 || mv_cnt - b_mv !== 1 || bus.move_index !== 5'd2) begin
      errors++; $display("FAIL abort_next got rx=%0d mv=%0d idx=%0d exp 1/1/2", rxv_cnt - b_rx, mv_cnt - b_mv, bus.move_index);
    end
  endtask

  task automatic test_rst_mid;
    logic [7:0] r;
    int lat, b_rx;
    bus.cs_n = 1'b0;
    idle(8);
    send_bits(8'hA5, 3, r, lat);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy got %b exp 1", bus.busy); end
    rst = 1'b1;
    bus.cs_n = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.miso_oe !== 1'b0 || bus.miso !== 1'b0 || bus.rx_data !== 8'h00 || bus.move_index !== 5'd0) begin
      errors++; $display("FAIL rstmid_outputs got busy=%b oe=%b miso=%b rx=%h idx=%0d exp all 0",
                         bus.busy, bus.miso_oe, bus.miso, bus.rx_data, bus.move_index);
    end
    idle(3);
    rst = 1'b0;
    idle(4);
    b_rx = rxv_cnt;
    send_bits(8'hA3, 8, r, lat);
    idle(8);
    checks++;
    if (rxv_cnt - b_rx !== 0 || bus.busy !== 1'b0 || bus.rx_data !== 8'h00) begin
      errors++; $display("FAIL rstmid_ignore got rx=%0d busy=%b data=%h exp 0/0/00", rxv_cnt - b_rx, bus.busy, bus.rx_data);
    end
  endtask

  task automatic test_order;
    checks++;
    if (order_err !== 0) begin errors++; $display("FAIL decode_timing got %0d stray pulses exp 0", order_err); end
  endtask

  initial begin
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.tx_data = 8'h00;
    test_reset;
    test_basic;
    test_move_err;
    test_mismatch;
    test_back_to_back;
    test_abort;
    test_rst_mid;
    test_order;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
